core_exu_lsu: RTL and testbench

Load/store execution unit on the consumer side of the decoder's LSU instruction bus. It accepts one decoded load or store per handshake, together with the ALU-computed effective address, the rs2 store data and the rd index. It drives a single-outstanding valid/ready data-memory port and returns sign/zero-extended load data on a writeback handshake. It sits in the EX stage beside the ALU and blocks the pipeline through `o_ready` while an access is in flight.

---
 rtl/core_exu_lsu_pkg.sv | 25 ++
 rtl/core_lsu_align.sv | 59 +++++
 rtl/core_exu_lsu.sv | 137 +++++++++++++
 tb/tb_core_exu_lsu.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_exu_lsu_pkg.sv
// Shared LSU definitions: instruction-bus bit positions, exception cause codes
// and the alignment predicate used when CORE_LSU_MISALIGN_TRAP_EN is defined.
package core_exu_lsu_pkg;

    localparam int CORE_LSU_INST_LOAD  = 0;
    localparam int CORE_LSU_INST_STORE = 1;
    localparam int CORE_LSU_INST_B     = 2;
    localparam int CORE_LSU_INST_H     = 3;
    localparam int CORE_LSU_INST_W     = 4;
    localparam int CORE_LSU_INST_LU    = 5;
    localparam int CORE_LSU_INST_WIDTH = 6;

    localparam int CORE_RFIDX_WIDTH = 5;

    localparam logic [1:0] CORE_EXC_LD_MISALIGN = 2'b01;
    localparam logic [1:0] CORE_EXC_ST_MISALIGN = 2'b10;
    localparam logic [1:0] CORE_EXC_BUS_ERR     = 2'b11;

    // Byte accesses are always aligned; halfwords need a[0]=0, words a[1:0]=0.
    function automatic logic lsu_misaligned(input logic [CORE_LSU_INST_WIDTH-1:0] inst,
                                            input logic [1:0]                     a);
        return (inst[CORE_LSU_INST_H] & a[0]) | (inst[CORE_LSU_INST_W] & (a != 2'b00));
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane steering: store strobe/data replication and load extract
// with sign or zero extension. Halfword/word offsets are aligned down.
module core_lsu_align #(
    parameter int XLEN = 32
) (
    input  logic            i_store,
    input  logic            i_b,
    input  logic            i_h,
    input  logic            i_w,
    input  logic            i_lu,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;

    function automatic logic [XLEN-1:0] ext8(input logic signed [7:0] v, input logic u);
        return u ? {{(XLEN-8){1'b0}}, v} : {{(XLEN-8){v[7]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic signed [15:0] v, input logic u);
        return u ? {{(XLEN-16){1'b0}}, v} : {{(XLEN-16){v[15]}}, v};
    endfunction

    always_comb begin
        w_shamt = 5'd0;
        if (i_b)      w_shamt = {i_addr_lo, 3'b000};
        else if (i_h) w_shamt = {i_addr_lo[1], 4'b0000};
    end

    assign w_shifted = i_rdata >> w_shamt;

    always_comb begin
        o_rdata = w_shifted;
        if (i_b)      o_rdata = ext8(w_shifted[7:0], i_lu);
        else if (i_h) o_rdata = ext16(w_shifted[15:0], i_lu);
    end

    // Loads never assert a strobe; the data lanes are don't-care for them.
    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_wdata;
        if (i_b) begin
            o_wdata = {4{i_wdata[7:0]}};
            if (i_store) o_wstrb = 4'b0001 << i_addr_lo;
        end else if (i_h) begin
            o_wdata = {2{i_wdata[15:0]}};
            if (i_store) o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        end else if (i_w & i_store) begin
            o_wstrb = 4'hF;
        end
    end

endmodule

// File: rtl/core_exu_lsu.sv
// Single-outstanding load/store unit between EX and the data-memory port.
// Optional alignment trap at accept: define CORE_LSU_MISALIGN_TRAP_EN.
module core_exu_lsu
    import core_exu_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [CORE_LSU_INST_WIDTH-1:0] i_lsu_inst,
    input  logic [XLEN-1:0]                i_addr,
    input  logic [XLEN-1:0]                i_wdata,
    input  logic [CORE_RFIDX_WIDTH-1:0]    i_rd_idx,
    output logic                           o_mem_req_valid,
    input  logic                           i_mem_req_ready,
    output logic [XLEN-1:0]                o_mem_addr,
    output logic                           o_mem_we,
    output logic [3:0]                     o_mem_wstrb,
    output logic [XLEN-1:0]                o_mem_wdata,
    input  logic                           i_mem_rsp_valid,
    input  logic [XLEN-1:0]                i_mem_rdata,
    input  logic                           i_mem_rsp_err,
    output logic                           o_wb_valid,
    input  logic                           i_wb_ready,
    output logic [CORE_RFIDX_WIDTH-1:0]    o_wb_rd_idx,
    output logic [XLEN-1:0]                o_wb_data,
    output logic                           o_st_done,
    output logic                           o_exc_valid,
    output logic [1:0]                     o_exc_cause,
    output logic [XLEN-1:0]                o_exc_addr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]                     r_state;
    logic [1:0]                     w_next;
    logic [CORE_LSU_INST_WIDTH-1:0] r_inst;
    logic [XLEN-1:0]                r_addr;
    logic [XLEN-1:0]                r_wdata;
    logic [XLEN-1:0]                r_wb_data;
    logic [CORE_RFIDX_WIDTH-1:0]    r_rd;
    logic                           r_mis_pend;
    logic [1:0]                     r_mis_cause;
    logic                           w_accept;
    logic                           w_mis;
    logic                           w_rsp;
    logic [XLEN-1:0]                w_ld_data;

    // Requests with LOAD and STORE both or neither set are consumed but ignored.
    assign w_accept = (r_state == S_IDLE) & i_valid
                    & (i_lsu_inst[CORE_LSU_INST_LOAD] ^ i_lsu_inst[CORE_LSU_INST_STORE]);
    assign w_rsp    = (r_state == S_RSP) & i_mem_rsp_valid;

`ifdef CORE_LSU_MISALIGN_TRAP_EN
    assign w_mis = lsu_misaligned(i_lsu_inst, i_addr[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept & ~w_mis) w_next = S_REQ;
            S_REQ:   if (i_mem_req_ready) w_next = S_RSP;
            S_RSP:   if (i_mem_rsp_valid)
                         w_next = (~i_mem_rsp_err & r_inst[CORE_LSU_INST_LOAD]) ? S_WB : S_IDLE;
            S_WB:    if (i_wb_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inst      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd        <= '0;
            r_wb_data   <= '0;
            r_mis_pend  <= 1'b0;
            r_mis_cause <= 2'b00;
        end else begin
            if (w_accept) begin
                r_inst      <= i_lsu_inst;
                r_addr      <= i_addr;
                r_wdata     <= i_wdata;
                r_rd        <= i_rd_idx;
                r_mis_cause <= i_lsu_inst[CORE_LSU_INST_LOAD] ? CORE_EXC_LD_MISALIGN
                                                              : CORE_EXC_ST_MISALIGN;
            end
            r_mis_pend <= w_accept & w_mis;
            if (w_rsp & ~i_mem_rsp_err & r_inst[CORE_LSU_INST_LOAD]) r_wb_data <= w_ld_data;
        end
    end

    // Completion pulses come straight from the response so they last one cycle.
    always_comb begin
        o_ready         = (r_state == S_IDLE);
        o_mem_req_valid = (r_state == S_REQ);
        o_wb_valid      = (r_state == S_WB);
        o_st_done       = w_rsp & ~i_mem_rsp_err & r_inst[CORE_LSU_INST_STORE];
        o_exc_valid     = r_mis_pend | (w_rsp & i_mem_rsp_err);
        o_exc_cause     = 2'b00;
        if (w_rsp & i_mem_rsp_err) o_exc_cause = CORE_EXC_BUS_ERR;
        else if (r_mis_pend)       o_exc_cause = r_mis_cause;
    end

    assign o_mem_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign o_mem_we    = r_inst[CORE_LSU_INST_STORE];
    assign o_exc_addr  = r_addr;
    assign o_wb_rd_idx = r_rd;
    assign o_wb_data   = r_wb_data;

    core_lsu_align #(.XLEN(XLEN)) u_align (
        .i_store   (r_inst[CORE_LSU_INST_STORE]),
        .i_b       (r_inst[CORE_LSU_INST_B]),
        .i_h       (r_inst[CORE_LSU_INST_H]),
        .i_w       (r_inst[CORE_LSU_INST_W]),
        .i_lu      (r_inst[CORE_LSU_INST_LU]),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (i_mem_rdata),
        .o_wstrb   (o_mem_wstrb),
        .o_wdata   (o_mem_wdata),
        .o_rdata   (w_ld_data)
    );

endmodule

// File: tb/tb_core_exu_lsu.sv
// Scoreboard bench for core_exu_lsu: expected results are queued per access
// and compared against what the DUT returns on its memory/writeback ports.
module tb_core_exu_lsu;
    import core_exu_lsu_pkg::*;

    logic                           clk = 1'b0;
    logic                           i_rst_n;
    logic                           i_valid;
    logic                           o_ready;
    logic [CORE_LSU_INST_WIDTH-1:0] i_lsu_inst;
    logic [31:0]                    i_addr, i_wdata;
    logic [CORE_RFIDX_WIDTH-1:0]    i_rd_idx;
    logic                           o_mem_req_valid, i_mem_req_ready;
    logic [31:0]                    o_mem_addr;
    logic                           o_mem_we;
    logic [3:0]                     o_mem_wstrb;
    logic [31:0]                    o_mem_wdata;
    logic                           i_mem_rsp_valid;
    logic [31:0]                    i_mem_rdata;
    logic                           i_mem_rsp_err;
    logic                           o_wb_valid, i_wb_ready;
    logic [CORE_RFIDX_WIDTH-1:0]    o_wb_rd_idx;
    logic [31:0]                    o_wb_data;
    logic                           o_st_done, o_exc_valid;
    logic [1:0]                     o_exc_cause;
    logic [31:0]                    o_exc_addr;

    always #5 clk = ~clk;

    core_exu_lsu #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_lsu_inst(i_lsu_inst), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd_idx(i_rd_idx),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wstrb(o_mem_wstrb),
        .o_mem_wdata(o_mem_wdata), .i_mem_rsp_valid(i_mem_rsp_valid),
        .i_mem_rdata(i_mem_rdata), .i_mem_rsp_err(i_mem_rsp_err),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd_idx(o_wb_rd_idx),
        .o_wb_data(o_wb_data), .o_st_done(o_st_done), .o_exc_valid(o_exc_valid),
        .o_exc_cause(o_exc_cause), .o_exc_addr(o_exc_addr)
    );

    int total = 0;
    int bad   = 0;

    // kind: 0 nothing, 1 writeback, 2 store done, 3 exception
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  cause;
        logic [31:0] eaddr;
        logic [31:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic        we;
        int          lat;
    } exp_t;

    typedef struct {
        exp_t r;
        int   n_wb;
        int   n_st;
        int   n_exc;
        int   n_req;
        bit   stable;
        bit   rdy_low;
        bit   timeout;
    } obs_t;

    exp_t sb_q[$];

    function automatic logic [CORE_LSU_INST_WIDTH-1:0] mk(input bit ld, input bit st,
                                                          input int sz, input bit lu);
        logic [CORE_LSU_INST_WIDTH-1:0] v;
        v = '0;
        v[CORE_LSU_INST_LOAD]  = ld;
        v[CORE_LSU_INST_STORE] = st;
        case (sz)
            1:       v[CORE_LSU_INST_B] = 1'b1;
            2:       v[CORE_LSU_INST_H] = 1'b1;
            default: v[CORE_LSU_INST_W] = 1'b1;
        endcase
        v[CORE_LSU_INST_LU] = lu;
        return v;
    endfunction

    function automatic exp_t mk_exp(input int kind, input logic [31:0] data, input logic [4:0] rd,
                                    input logic [1:0] cause, input logic [31:0] eaddr,
                                    input logic [31:0] maddr, input logic [3:0] wstrb,
                                    input logic [31:0] mwdata, input logic we, input int lat);
        exp_t e;
        e.kind = kind; e.data = data; e.rd = rd; e.cause = cause; e.eaddr = eaddr;
        e.maddr = maddr; e.wstrb = wstrb; e.mwdata = mwdata; e.we = we; e.lat = lat;
        return e;
    endfunction

    // Drives one request and acts as the memory and writeback consumer.
    task automatic run_access(input logic [CORE_LSU_INST_WIDTH-1:0] inst, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, input int req_wait,
                              input logic [31:0] rdata, input bit err, input int wb_wait,
                              output obs_t o);
        int phase, wcnt, bcnt, post;
        bit seen_req;
        o.r = mk_exp(0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 0);
        o.n_wb = 0; o.n_st = 0; o.n_exc = 0; o.n_req = 0;
        o.stable = 1'b1; o.rdy_low = 1'b1; o.timeout = 1'b0;
        phase = 0; wcnt = 0; bcnt = 0; post = -1; seen_req = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_lsu_inst = inst; i_addr = addr; i_wdata = wdata; i_rd_idx = rd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            i_valid = 1'b0; i_lsu_inst = '0;
            i_mem_req_ready = (phase == 0) && (wcnt >= req_wait);
            i_mem_rsp_valid = (phase == 1);
            i_mem_rdata     = (phase == 1) ? rdata : 32'h0;
            i_mem_rsp_err   = (phase == 1) && err;
            i_wb_ready      = (phase == 2) && (bcnt >= wb_wait);
            #1;
            if (phase < 3 && o_ready !== 1'b0) o.rdy_low = 1'b0;
            if (o_mem_req_valid === 1'b1) begin
                o.n_req++;
                if (!seen_req) begin
                    seen_req = 1'b1;
                    o.r.maddr = o_mem_addr; o.r.wstrb = o_mem_wstrb;
                    o.r.mwdata = o_mem_wdata; o.r.we = o_mem_we;
                end else if (o.r.maddr !== o_mem_addr || o.r.wstrb !== o_mem_wstrb ||
                             o.r.mwdata !== o_mem_wdata || o.r.we !== o_mem_we) begin
                    o.stable = 1'b0;
                end
            end
            if (o_wb_valid === 1'b1 && (i_wb_ready || phase == 3)) o.n_wb++;
            if (o_wb_valid === 1'b1 && o.r.kind == 0) begin
                o.r.kind = 1; o.r.data = o_wb_data; o.r.rd = o_wb_rd_idx; o.r.lat = c;
            end
            if (o_st_done === 1'b1) begin
                o.n_st++;
                if (o.r.kind == 0) begin o.r.kind = 2; o.r.lat = c; end
            end
            if (o_exc_valid === 1'b1) begin
                o.n_exc++;
                if (o.r.kind == 0) begin
                    o.r.kind = 3; o.r.cause = o_exc_cause; o.r.eaddr = o_exc_addr; o.r.lat = c;
                end
            end
            case (phase)
                0: if (o_mem_req_valid === 1'b1) begin
                       if (i_mem_req_ready) phase = 1; else wcnt++;
                   end
                1: phase = 2;
                2: if (o_wb_valid === 1'b1) begin
                       if (i_wb_ready) phase = 3; else bcnt++;
                   end
                default: ;
            endcase
            if (phase != 3 && (o.r.kind == 2 || o.r.kind == 3)) phase = 3;
            if (phase == 3) begin
                post++;
                if (post >= 3) break;
            end
        end
        if (phase != 3) o.timeout = 1'b1;
        i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0; i_wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [143:0] v;
        v = {o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wstrb, o_mem_wdata, o_wb_valid,
             o_wb_rd_idx, o_wb_data, o_st_done, o_exc_valid, o_exc_cause, o_exc_addr};
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        total++; if (v !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", v); end
    endtask

    task automatic test_lw();
        obs_t o; exp_t e;
        sb_q.push_back(mk_exp(1, 32'hDEADBEEF, 5'd7, 2'b00, 32'h0, 32'h100, 4'h0, 32'h0, 1'b0, 3));
        run_access(mk(1, 0, 4, 0), 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.kind !== e.kind) begin bad++; $display("FAIL lw_kind got=%0d want=%0d", o.r.kind, e.kind); end
        total++; if (o.r.data !== e.data) begin bad++; $display("FAIL lw_data got=%h want=%h", o.r.data, e.data); end
        total++; if (o.r.rd !== e.rd) begin bad++; $display("FAIL lw_rd got=%0d want=%0d", o.r.rd, e.rd); end
        total++; if (o.r.lat !== e.lat) begin bad++; $display("FAIL lw_latency got=%0d want=%0d", o.r.lat, e.lat); end
        total++; if (o.r.maddr !== e.maddr) begin bad++; $display("FAIL lw_addr got=%h want=%h", o.r.maddr, e.maddr); end
        total++; if ({o.r.we, o.r.wstrb} !== {e.we, e.wstrb}) begin bad++; $display("FAIL lw_we_strb got=%b want=%b", {o.r.we, o.r.wstrb}, {e.we, e.wstrb}); end
        total++; if (o.n_wb !== 1 || o.timeout) begin bad++; $display("FAIL lw_wb_count got=%0d timeout=%0d want=1", o.n_wb, o.timeout); end
    endtask

    task automatic test_lb_lbu();
        obs_t o; exp_t e;
        sb_q.push_back(mk_exp(1, 32'hFFFFFF80, 5'd3, 2'b00, 32'h0, 32'h100, 4'h0, 32'h0, 1'b0, 3));
        sb_q.push_back(mk_exp(1, 32'h00000080, 5'd4, 2'b00, 32'h0, 32'h100, 4'h0, 32'h0, 1'b0, 3));
        run_access(mk(1, 0, 1, 0), 32'h103, 32'h0, 5'd3, 0, 32'h80FF1234, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.data !== e.data) begin bad++; $display("FAIL lb_data got=%h want=%h", o.r.data, e.data); end
        total++; if (o.r.maddr !== e.maddr) begin bad++; $display("FAIL lb_addr got=%h want=%h", o.r.maddr, e.maddr); end
        run_access(mk(1, 0, 1, 1), 32'h103, 32'h0, 5'd4, 0, 32'h80FF1234, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.data !== e.data) begin bad++; $display("FAIL lbu_data got=%h want=%h", o.r.data, e.data); end
        total++; if (o.r.rd !== e.rd) begin bad++; $display("FAIL lbu_rd got=%0d want=%0d", o.r.rd, e.rd); end
    endtask

    task automatic test_sh();
        obs_t o; exp_t e;
        sb_q.push_back(mk_exp(2, 32'h0, 5'd0, 2'b00, 32'h0, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1, 2));
        run_access(mk(0, 1, 2, 0), 32'h202, 32'h1234ABCD, 5'd0, 0, 32'h0, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.kind !== e.kind || o.r.lat !== e.lat) begin bad++; $display("FAIL sh_done got=%0d@%0d want=%0d@%0d", o.r.kind, o.r.lat, e.kind, e.lat); end
        total++; if (o.r.wstrb !== e.wstrb) begin bad++; $display("FAIL sh_wstrb got=%b want=%b", o.r.wstrb, e.wstrb); end
        total++; if (o.r.mwdata !== e.mwdata) begin bad++; $display("FAIL sh_wdata got=%h want=%h", o.r.mwdata, e.mwdata); end
        total++; if (o.r.we !== e.we || o.r.maddr !== e.maddr) begin bad++; $display("FAIL sh_we_addr got=%b/%h want=%b/%h", o.r.we, o.r.maddr, e.we, e.maddr); end
        total++; if (o.n_st !== 1 || o.n_wb !== 0) begin bad++; $display("FAIL sh_pulse got=%0d wb=%0d want=1 wb=0", o.n_st, o.n_wb); end
    endtask

    task automatic test_back_pressure();
        obs_t o; exp_t e;
        sb_q.push_back(mk_exp(1, 32'h0BADF00D, 5'd9, 2'b00, 32'h0, 32'h104, 4'h0, 32'h0, 1'b0, 6));
        run_access(mk(1, 0, 4, 0), 32'h104, 32'h0, 5'd9, 3, 32'h0BADF00D, 1'b0, 2, o);
        e = sb_q.pop_front();
        total++; if (o.stable !== 1'b1 || o.n_req !== 4) begin bad++; $display("FAIL bp_req_stable got=%0d req_cycles=%0d want=1 req_cycles=4", o.stable, o.n_req); end
        total++; if (o.rdy_low !== 1'b1) begin bad++; $display("FAIL bp_ready_low got=%0d want=1", o.rdy_low); end
        total++; if (o.n_wb !== 1) begin bad++; $display("FAIL bp_wb_count got=%0d want=1", o.n_wb); end
        total++; if (o.r.data !== e.data || o.r.lat !== e.lat) begin bad++; $display("FAIL bp_wb got=%h@%0d want=%h@%0d", o.r.data, o.r.lat, e.data, e.lat); end
    endtask

    task automatic test_bus_error();
        obs_t o; exp_t e;
        sb_q.push_back(mk_exp(3, 32'h0, 5'd0, CORE_EXC_BUS_ERR, 32'h105, 32'h104, 4'h0, 32'h0, 1'b0, 2));
        run_access(mk(1, 0, 1, 0), 32'h105, 32'h0, 5'd11, 0, 32'h12345678, 1'b1, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.kind !== e.kind || o.r.cause !== e.cause) begin bad++; $display("FAIL err_cause got=%0d/%b want=%0d/%b", o.r.kind, o.r.cause, e.kind, e.cause); end
        total++; if (o.r.eaddr !== e.eaddr) begin bad++; $display("FAIL err_addr got=%h want=%h", o.r.eaddr, e.eaddr); end
        total++; if (o.n_wb !== 0 || o.n_exc !== 1) begin bad++; $display("FAIL err_pulses got=wb%0d exc%0d want=wb0 exc1", o.n_wb, o.n_exc); end
    endtask

    task automatic test_misaligned();
        obs_t o; exp_t e;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
        sb_q.push_back(mk_exp(3, 32'h0, 5'd0, CORE_EXC_LD_MISALIGN, 32'h101, 32'h0, 4'h0, 32'h0, 1'b0, 1));
        sb_q.push_back(mk_exp(3, 32'h0, 5'd0, CORE_EXC_ST_MISALIGN, 32'h203, 32'h0, 4'h0, 32'h0, 1'b0, 1));
        run_access(mk(1, 0, 4, 0), 32'h101, 32'h0, 5'd5, 0, 32'h11223344, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.kind !== e.kind || o.r.cause !== e.cause || o.r.lat !== e.lat) begin bad++; $display("FAIL mis_lw got=%0d/%b@%0d want=%0d/%b@%0d", o.r.kind, o.r.cause, o.r.lat, e.kind, e.cause, e.lat); end
        total++; if (o.n_req !== 0 || o.r.eaddr !== e.eaddr) begin bad++; $display("FAIL mis_lw_noreq got=%0d/%h want=0/%h", o.n_req, o.r.eaddr, e.eaddr); end
        run_access(mk(0, 1, 2, 0), 32'h203, 32'h5566, 5'd0, 0, 32'h0, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.cause !== e.cause || o.n_req !== 0 || o.n_st !== 0) begin bad++; $display("FAIL mis_sh got=%b req%0d st%0d want=%b req0 st0", o.r.cause, o.n_req, o.n_st, e.cause); end
`else
        sb_q.push_back(mk_exp(1, 32'h11223344, 5'd5, 2'b00, 32'h0, 32'h100, 4'h0, 32'h0, 1'b0, 3));
        sb_q.push_back(mk_exp(2, 32'h0, 5'd0, 2'b00, 32'h0, 32'h200, 4'b1100, 32'h55665566, 1'b1, 2));
        run_access(mk(1, 0, 4, 0), 32'h101, 32'h0, 5'd5, 0, 32'h11223344, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.maddr !== e.maddr || o.n_exc !== 0) begin bad++; $display("FAIL mis_lw_addr got=%h exc%0d want=%h exc0", o.r.maddr, o.n_exc, e.maddr); end
        total++; if (o.r.kind !== e.kind || o.r.data !== e.data) begin bad++; $display("FAIL mis_lw_wb got=%0d/%h want=%0d/%h", o.r.kind, o.r.data, e.kind, e.data); end
        run_access(mk(0, 1, 2, 0), 32'h203, 32'h5566, 5'd0, 0, 32'h0, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.wstrb !== e.wstrb || o.r.mwdata !== e.mwdata || o.n_st !== 1) begin bad++; $display("FAIL mis_sh got=%b/%h st%0d want=%b/%h st1", o.r.wstrb, o.r.mwdata, o.n_st, e.wstrb, e.mwdata); end
`endif
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e;
        sb_q.push_back(mk_exp(1, 32'hFFFF8001, 5'd12, 2'b00, 32'h0, 32'h100, 4'h0, 32'h0, 1'b0, 3));
        sb_q.push_back(mk_exp(1, 32'h00008001, 5'd13, 2'b00, 32'h0, 32'h100, 4'h0, 32'h0, 1'b0, 3));
        sb_q.push_back(mk_exp(2, 32'h0, 5'd0, 2'b00, 32'h0, 32'h300, 4'hF, 32'hCAFEF00D, 1'b1, 2));
        sb_q.push_back(mk_exp(2, 32'h0, 5'd0, 2'b00, 32'h0, 32'h200, 4'b0010, 32'h77777777, 1'b1, 2));
        run_access(mk(1, 0, 2, 0), 32'h102, 32'h0, 5'd12, 0, 32'h80011234, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.data !== e.data || o.r.rd !== e.rd) begin bad++; $display("FAIL lh_data got=%h/%0d want=%h/%0d", o.r.data, o.r.rd, e.data, e.rd); end
        run_access(mk(1, 0, 2, 1), 32'h102, 32'h0, 5'd13, 0, 32'h80011234, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.data !== e.data) begin bad++; $display("FAIL lhu_data got=%h want=%h", o.r.data, e.data); end
        run_access(mk(0, 1, 4, 0), 32'h300, 32'hCAFEF00D, 5'd0, 1, 32'h0, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.wstrb !== e.wstrb || o.r.mwdata !== e.mwdata || o.r.maddr !== e.maddr) begin bad++; $display("FAIL sw_lanes got=%b/%h/%h want=%b/%h/%h", o.r.wstrb, o.r.mwdata, o.r.maddr, e.wstrb, e.mwdata, e.maddr); end
        run_access(mk(0, 1, 1, 0), 32'h201, 32'h00000077, 5'd0, 0, 32'h0, 1'b0, 0, o);
        e = sb_q.pop_front();
        total++; if (o.r.wstrb !== e.wstrb || o.r.mwdata !== e.mwdata || o.n_st !== 1) begin bad++; $display("FAIL sb_lanes got=%b/%h st%0d want=%b/%h st1", o.r.wstrb, o.r.mwdata, o.n_st, e.wstrb, e.mwdata); end
    endtask

    task automatic test_drop();
        int n_bad_evt;
        for (int k = 0; k < 2; k++) begin
            n_bad_evt = 0;
            @(negedge clk);
            i_valid = 1'b1; i_addr = 32'h400; i_rd_idx = 5'd1;
            i_lsu_inst = (k == 0) ? mk(1, 1, 4, 0) : mk(0, 0, 4, 0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                i_valid = 1'b0; i_lsu_inst = '0;
                #1;
                if (o_ready !== 1'b1 || o_mem_req_valid !== 1'b0 || o_exc_valid !== 1'b0 ||
                    o_st_done !== 1'b0 || o_wb_valid !== 1'b0) n_bad_evt++;
            end
            total++; if (n_bad_evt !== 0) begin bad++; $display("FAIL drop_%0d got=%0d events want=0", k, n_bad_evt); end
        end
    endtask

    task automatic test_reset_mid();
        logic [143:0] v;
        int n_bad_evt;
        @(negedge clk);
        i_valid = 1'b1; i_lsu_inst = mk(1, 0, 4, 0); i_addr = 32'h500; i_rd_idx = 5'd6;
        @(negedge clk);
        i_valid = 1'b0; i_lsu_inst = '0; i_mem_req_ready = 1'b1;
        @(negedge clk);
        i_mem_req_ready = 1'b0;
        #1;
        total++; if (o_ready !== 1'b0 || o_mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_in_rsp got=rdy%b req%b want=rdy0 req0", o_ready, o_mem_req_valid); end
        i_rst_n = 1'b0;
        #1;
        v = {o_mem_req_valid, o_mem_addr, o_mem_we, o_mem_wstrb, o_mem_wdata, o_wb_valid,
             o_wb_rd_idx, o_wb_data, o_st_done, o_exc_valid, o_exc_cause, o_exc_addr};
        total++; if (o_ready !== 1'b1 || v !== '0) begin bad++; $display("FAIL rst_mid_clear got=rdy%b %h want=rdy1 0", o_ready, v); end
        @(negedge clk);
        i_rst_n = 1'b1;
        n_bad_evt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_mem_rsp_valid = (c == 0); i_mem_rdata = 32'hA5A5A5A5;
            #1;
            if (o_ready !== 1'b1 || o_wb_valid !== 1'b0 || o_exc_valid !== 1'b0 ||
                o_st_done !== 1'b0 || o_mem_req_valid !== 1'b0) n_bad_evt++;
        end
        i_mem_rsp_valid = 1'b0;
        total++; if (n_bad_evt !== 0) begin bad++; $display("FAIL rst_mid_late_rsp got=%0d events want=0", n_bad_evt); end
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_lsu_inst = '0; i_addr = '0; i_wdata = '0;
        i_rd_idx = '0; i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rdata = '0;
        i_mem_rsp_err = 1'b0; i_wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        i_rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_back_pressure();
        test_bus_error();
        test_misaligned();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_lw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
